move_sequencer: RTL and testbench

- Executes one 2048 move (left/right/up/down) on the 4x4 board held in the board memory. The move is processed line by line: 4 cell reads, compaction and merge, then 4 cell writes.
- Controlled by the game FSM with a start/done handshake. The FSM issues start during its MOV state and waits for done before continuing.
- Reports whether the board changed, the score increment, win detection and the empty-cell count, which the spawn logic and lose logic use.

---
 rtl/move_sequencer_pkg.sv | 40 ++++
 rtl/move_sequencer_if.sv | 31 +++
 rtl/move_sequencer_line_merge.sv | 66 ++++++
 rtl/move_sequencer.sv | 126 ++++++++++++
 tb/tb_move_sequencer.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/move_sequencer_pkg.sv
// Shared 2048 types: tile exponents, move directions, sequencer states and the
// line/position to board-address mapping.
package pkg_2048;

    localparam int BOARD_N = 4;

    typedef logic [3:0] exp_t;

    typedef enum logic [2:0] {
        NONE  = 3'b000,
        LEFT  = 3'b001,
        RIGHT = 3'b010,
        UP    = 3'b011,
        DOWN  = 3'b100
    } dir_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_MRG,
        S_WR,
        S_DONE
    } seq_state_t;

    function automatic logic dir_valid(input logic [2:0] d);
        return (d >= 3'd1) && (d <= 3'd4);
    endfunction

    // p = 0 is the cell tiles slide toward
    function automatic logic [3:0] cell_addr(input dir_t d, input logic [1:0] l,
                                             input logic [1:0] p);
        case (d)
            RIGHT:   return {l, 2'd3 - p};
            UP:      return {p, l};
            DOWN:    return {2'd3 - p, l};
            default: return {l, p};
        endcase
    endfunction

endpackage

// File: rtl/move_sequencer_if.sv
// Start/done handshake, result outputs and board-memory port of the move sequencer.
interface move_sequencer_if #(parameter int SCORE_W = 20);
    import pkg_2048::*;

    logic               start;
    logic [2:0]         dir;
    logic               busy;
    logic               done;
    logic               moved;
    logic               win;
    logic [4:0]         empty_cnt;
    logic [SCORE_W-1:0] score_delta;
    logic [3:0]         rd_addr;
    exp_t               rd_data;
    logic               wr_en;
    logic [3:0]         wr_addr;
    exp_t               wr_data;

    modport master (
        output start, dir, rd_data,
        input  busy, done, moved, win, empty_cnt, score_delta,
               rd_addr, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  start, dir, rd_data,
        output busy, done, moved, win, empty_cnt, score_delta,
               rd_addr, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/move_sequencer_line_merge.sv
// Combinational slide-and-merge of one 4-cell line toward position 0; also used
// by the lose check to test whether any move is possible.
module line_merge
    import pkg_2048::*;
#(
    parameter int WIN_EXP = 11
) (
    input  exp_t        cells  [BOARD_N],
    output exp_t        merged [BOARD_N],
    output logic        changed,
    output logic [16:0] score,
    output logic        win,
    output logic [2:0]  zeros
);

    // one spare zero slot so the pair compare at the last position stays in range
    exp_t       comp [BOARD_N+1];
    logic [2:0] n;
    logic [2:0] j;
    logic       skip;
    logic [4:0] up_exp;

    always_comb begin
        for (int i = 0; i <= BOARD_N; i++) comp[i] = '0;
        for (int i = 0; i < BOARD_N; i++) merged[i] = '0;
        n       = '0;
        j       = '0;
        skip    = 1'b0;
        up_exp  = '0;
        score   = '0;
        win     = 1'b0;
        changed = 1'b0;
        zeros   = '0;

        for (int i = 0; i < BOARD_N; i++) begin
            if (cells[i] != '0) begin
                comp[n] = cells[i];
                n = n + 3'd1;
            end
        end

        // a merged tile consumes its partner, so it can never merge again
        for (int i = 0; i < BOARD_N; i++) begin
            up_exp = {1'b0, comp[i]} + 5'd1;
            if (skip) begin
                skip = 1'b0;
            end else if (comp[i] != '0) begin
                if (comp[i] == comp[i+1] && comp[i] != 4'hF) begin
                    merged[j[1:0]] = up_exp[3:0];
                    score = score + (17'd1 << up_exp);
                    win   = win | (up_exp >= 5'(WIN_EXP));
                    skip  = 1'b1;
                end else begin
                    merged[j[1:0]] = comp[i];
                end
                j = j + 3'd1;
            end
        end

        for (int i = 0; i < BOARD_N; i++) begin
            changed = changed | (merged[i] != cells[i]);
            zeros   = zeros + {2'b00, merged[i] == '0};
        end
    end

endmodule

// File: rtl/move_sequencer.sv
// Executes one 2048 move on the board memory, line by line: 4 reads, one merge
// cycle, 4 writes; reports moved/win/score/empty results on done.
module move_sequencer
    import pkg_2048::*;
#(
    parameter int WIN_EXP = 11,
    parameter int SCORE_W = 20
) (
    input logic             clk,
    input logic             rst,
    move_sequencer_if.slave bus
);

    seq_state_t   state;
    dir_t         dir_q;
    logic [1:0]   line_idx;
    logic [2:0]   cnt;
    exp_t         line_buf [BOARD_N];
    exp_t         line_out [BOARD_N];

    exp_t         m_out [BOARD_N];
    logic         m_changed;
    logic [16:0]  m_score;
    logic         m_win;
    logic [2:0]   m_zeros;
    logic [SCORE_W:0] score_sum;

    line_merge #(.WIN_EXP(WIN_EXP)) u_merge (
        .cells   (line_buf),
        .merged  (m_out),
        .changed (m_changed),
        .score   (m_score),
        .win     (m_win),
        .zeros   (m_zeros)
    );

    assign score_sum = {1'b0, bus.score_delta} + (SCORE_W+1)'(m_score);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            dir_q           <= LEFT;
            line_idx        <= '0;
            cnt             <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.moved       <= 1'b0;
            bus.win         <= 1'b0;
            bus.empty_cnt   <= '0;
            bus.score_delta <= '0;
            bus.rd_addr     <= '0;
            bus.wr_en       <= 1'b0;
            bus.wr_addr     <= '0;
            bus.wr_data     <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        bus.moved       <= 1'b0;
                        bus.win         <= 1'b0;
                        bus.score_delta <= '0;
                        if (dir_valid(bus.dir)) begin
                            dir_q         <= dir_t'(bus.dir);
                            bus.empty_cnt <= '0;
                            line_idx      <= '0;
                            cnt           <= '0;
                            bus.busy      <= 1'b1;
                            bus.rd_addr   <= cell_addr(dir_t'(bus.dir), 2'd0, 2'd0);
                            state         <= S_RD;
                        end else begin
                            // invalid direction: report a no-op move, keep empty_cnt
                            bus.done <= 1'b1;
                            state    <= S_DONE;
                        end
                    end
                end
                S_RD: begin
                    // read data trails its address by one cycle
                    if (cnt != 3'd0) line_buf[cnt[1:0] - 2'd1] <= bus.rd_data;
                    if (cnt < 3'd3) bus.rd_addr <= cell_addr(dir_q, line_idx, cnt[1:0] + 2'd1);
                    if (cnt == 3'd4) begin
                        cnt   <= '0;
                        state <= S_MRG;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                S_MRG: begin
                    line_out        <= m_out;
                    bus.moved       <= bus.moved | m_changed;
                    bus.win         <= bus.win | m_win;
                    bus.empty_cnt   <= bus.empty_cnt + 5'(m_zeros);
                    bus.score_delta <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                    bus.wr_en       <= 1'b1;
                    bus.wr_addr     <= cell_addr(dir_q, line_idx, 2'd0);
                    bus.wr_data     <= m_out[0];
                    cnt             <= '0;
                    state           <= S_WR;
                end
                S_WR: begin
                    if (cnt == 3'd3) begin
                        bus.wr_en <= 1'b0;
                        cnt       <= '0;
                        if (line_idx == 2'd3) begin
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            line_idx    <= line_idx + 2'd1;
                            bus.rd_addr <= cell_addr(dir_q, line_idx + 2'd1, 2'd0);
                            state       <= S_RD;
                        end
                    end else begin
                        cnt         <= cnt + 3'd1;
                        bus.wr_addr <= cell_addr(dir_q, line_idx, cnt[1:0] + 2'd1);
                        bus.wr_data <= line_out[cnt[1:0] + 2'd1];
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_move_sequencer.sv
// Table-driven bench for move_sequencer with a board memory model and a queue of
// expected move results popped on each done pulse.
module tb_move_sequencer;
    import pkg_2048::*;

    typedef struct {
        logic [2:0]  d;
        logic [63:0] init;
        logic [63:0] fin;
        logic        moved;
        logic        win;
        int          score;
        int          empty;
        int          lat;
        int          writes;
    } vec_t;

    logic clk;
    logic rst;
    move_sequencer_if #(.SCORE_W(20)) bus ();

    move_sequencer #(.WIN_EXP(11), .SCORE_W(20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // board memory: synchronous read, writes counted per move
    exp_t        mem [16];
    logic        load;
    logic [63:0] load_board;
    int          wr_count;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 16; i++) mem[i] <= load_board[4*i +: 4];
            wr_count <= 0;
        end else if (bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_data;
            wr_count <= wr_count + 1;
        end
        bus.rd_data <= mem[bus.rd_addr];
    end

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t exp_q[$];
    vec_t tbl[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // rows given with column 0 as the most significant nibble
    function automatic logic [63:0] brd(input logic [15:0] r0, input logic [15:0] r1,
                                        input logic [15:0] r2, input logic [15:0] r3);
        logic [15:0] rows [4];
        logic [63:0] b;
        rows[0] = r0; rows[1] = r1; rows[2] = r2; rows[3] = r3;
        b = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                b[4*(r*4+c) +: 4] = rows[r][15-4*c -: 4];
        return b;
    endfunction

    function automatic logic [63:0] board();
        logic [63:0] b;
        for (int i = 0; i < 16; i++) b[4*i +: 4] = mem[i];
        return b;
    endfunction

    task automatic load_mem(input logic [63:0] b);
        @(negedge clk);
        load_board = b;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic run(input vec_t v, input int dup_cyc, input int rst_cyc);
        int   cyc;
        vec_t e;
        load_mem(v.init);
        if (rst_cyc == 0) exp_q.push_back(v);
        @(negedge clk);
        bus.start = 1'b1;
        bus.dir   = v.d;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        if (v.lat > 1) chk("busy_rise", 64'(bus.busy), 64'd1);
        while (!bus.done && cyc < 200) begin
            if (rst_cyc != 0 && cyc == rst_cyc) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_busy", 64'(bus.busy), 64'd0);
                chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
                chk("rst_partial_writes", 64'(wr_count), 64'd4);
                return;
            end
            if (dup_cyc != 0 && cyc == dup_cyc + 1) bus.start = 1'b0;
            if (dup_cyc != 0 && cyc == dup_cyc) begin
                bus.start = 1'b1;
                bus.dir   = 3'b010;
            end
            @(negedge clk);
            cyc++;
        end
        chk("done_cycle", 64'(cyc), 64'(v.lat));
        chk("busy_at_done", 64'(bus.busy), 64'd0);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("moved", 64'(bus.moved), 64'(e.moved));
            chk("win", 64'(bus.win), 64'(e.win));
            chk("score_delta", 64'(bus.score_delta), 64'(e.score));
            chk("empty_cnt", 64'(bus.empty_cnt), 64'(e.empty));
        end else begin
            chk("scoreboard_empty", 64'd1, 64'(exp_q.size()));
        end
        @(negedge clk);
        chk("done_pulse", 64'(bus.done), 64'd0);
        chk("board", board(), v.fin);
        chk("writes", 64'(wr_count), 64'(v.writes));
        @(negedge clk);
        chk("idle_after", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        vec_t r;
        tbl[0] = '{LEFT,  brd(16'h1122, 0, 0, 0), brd(16'h2300, 0, 0, 0), 1, 0, 12,   14, 41, 16};
        tbl[1] = '{LEFT,  brd(16'h1111, 0, 0, 0), brd(16'h2200, 0, 0, 0), 1, 0, 8,    14, 41, 16};
        tbl[2] = '{RIGHT, brd(0, 16'h1000, 0, 0), brd(0, 16'h0001, 0, 0), 1, 0, 0,    15, 41, 16};
        tbl[3] = '{UP,    brd(0, 0, 16'h0030, 16'h0030), brd(16'h0040, 0, 0, 0), 1, 0, 16, 15, 41, 16};
        tbl[4] = '{DOWN,  brd(16'hA000, 0, 0, 16'hA000), brd(0, 0, 0, 16'hB000), 1, 1, 2048, 15, 41, 16};
        tbl[5] = '{3'b000, brd(0, 0, 0, 16'hB000), brd(0, 0, 0, 16'hB000), 0, 0, 0,   15, 1, 0};
        tbl[6] = '{3'b111, brd(0, 0, 0, 16'hB000), brd(0, 0, 0, 16'hB000), 0, 0, 0,   15, 1, 0};
        tbl[7] = '{LEFT,  brd(16'h1234, 16'h2100, 16'h5000, 0),
                          brd(16'h1234, 16'h2100, 16'h5000, 0), 0, 0, 0, 9, 41, 16};
        tbl[8] = '{LEFT,  brd(16'hFF00, 16'h0202, 0, 0), brd(16'hFF00, 16'h3000, 0, 0), 1, 0, 8, 13, 41, 16};

        rst = 1'b1;
        load = 1'b0;
        load_board = '0;
        bus.start = 1'b0;
        bus.dir = 3'b000;
        repeat (3) @(negedge clk);
        chk("rst_busy0", 64'(bus.busy), 64'd0);
        chk("rst_done0", 64'(bus.done), 64'd0);
        chk("rst_wr_en0", 64'(bus.wr_en), 64'd0);
        chk("rst_results", {bus.moved, bus.win, bus.empty_cnt, bus.score_delta}, 64'd0);
        chk("rst_addrs", {bus.rd_addr, bus.wr_addr, bus.wr_data}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run(tbl[i], 0, 0);

        // a second start while busy must not disturb the move in flight
        run(tbl[0], 5, 0);

        // reset mid-move, then a normal move
        r = tbl[0];
        run(r, 0, 15);
        run(tbl[2], 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
